// File: rtl/alu_exec_seq.sv
// ----------------------------------------------------------------------------
// alu_exec_seq
// Execute stage that sits after the ALU control decoder. Takes a 4-bit
// alu_opcode and two operands, returns a registered result plus zero,
// signed-overflow and illegal-opcode flags. Logic/add/sub/compare ops finish
// on the accept edge; MUL runs a WIDTH-step shift-add engine. Valid/ready
// handshakes on both sides let a downstream consumer stall this stage.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    operands + alu_opcode valid this cycle
//   in_ready    stage can accept an operation this cycle
//   alu_opcode  operation select
//   op_a, op_b  operands (rs1, rs2/imm)
//   out_valid   result/flags valid, held until out_ready
//   out_ready   consumer takes the result this cycle
//   result      operation result
//   zero        result == 0
//   overflow    signed overflow for ADD/SUB, 0 otherwise
//   illegal_op  opcode not recognised; result forced to 0
// ----------------------------------------------------------------------------
module alu_exec_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal_op
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] b_neg_s, sum_s, diff_s, alu_res_s, acc_step_s;
   logic             alu_ovf_s, alu_ill_s, is_mul_s, accept_s;

   // Subtraction is A + (~B + 1); overflow uses the sign of that negated B.
   assign b_neg_s = ~op_b + {{(WIDTH-1){1'b0}}, 1'b1};
   assign sum_s   = op_a + op_b;
   assign diff_s  = op_a + b_neg_s;

   // A MUL partial product is added only when the current multiplier LSB is set.
   assign acc_step_s = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

   assign out_valid  = (state_q == ST_DONE);
   // In DONE a new op can enter on the same edge the held result is consumed.
   assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept_s   = in_valid && in_ready;
   assign result     = result_q;
   assign zero       = zero_q;
   assign overflow   = ovf_q;
   assign illegal_op = ill_q;

   // Single-cycle operation decode and evaluation.
   always_comb begin
      alu_res_s = ZERO_W;
      alu_ovf_s = 1'b0;
      alu_ill_s = 1'b0;
      is_mul_s  = 1'b0;
      case (alu_opcode)
         OP_AND: alu_res_s = op_a & op_b;
         OP_OR:  alu_res_s = op_a | op_b;
         OP_NOR: alu_res_s = ~(op_a | op_b);
         OP_ADD: begin
            alu_res_s = sum_s;
            alu_ovf_s = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_s[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_s = diff_s;
            alu_ovf_s = (op_a[WIDTH-1] == b_neg_s[WIDTH-1]) && (diff_s[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_MUL: is_mul_s = 1'b1;
         default: alu_ill_s = 1'b1;
      endcase
   end

   // Next-state logic for the IDLE/BUSY/DONE control FSM and its datapath.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               if (is_mul_s) begin
                  mcand_d = op_a;
                  mplr_d  = op_b;
                  acc_d   = ZERO_W;
                  cnt_d   = CNT_LOAD;
                  state_d = ST_BUSY;
               end else begin
                  result_d = alu_res_s;
                  zero_d   = (alu_res_s == ZERO_W);
                  ovf_d    = alu_ovf_s;
                  ill_d    = alu_ill_s;
                  state_d  = ST_DONE;
               end
            end else if ((state_q == ST_DONE) && out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_BUSY: begin
            acc_d   = acc_step_s;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CNT_ONE;
            // The last step's partial product goes straight into the result.
            if (cnt_q == CNT_ONE) begin
               result_d = acc_step_s;
               zero_d   = (acc_step_s == ZERO_W);
               ovf_d    = 1'b0;
               ill_d    = 1'b0;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= ZERO_W;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
         mcand_q  <= ZERO_W;
         mplr_q   <= ZERO_W;
         acc_q    <= ZERO_W;
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         ill_q    <= ill_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
